// File: rtl/dm_store_buffer_pkg.sv
// Shared constants for the dm_4k posted-write store buffer.
// Entry layout is {sb, addr, data} with data in the low bits.
package dm_store_buffer_pkg;

  localparam int unsigned DmAw     = 12;
  localparam int unsigned DataW    = 32;
  localparam int unsigned DefDepth = 4;

  localparam int unsigned DataOff = 0;
  localparam int unsigned AddrOff = DataW;

  function automatic int unsigned entry_w(int unsigned aw);
    return 1 + aw + DataW;
  endfunction

  function automatic int unsigned sb_off(int unsigned aw);
    return DataW + aw;
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// CPU-side store/load request bus and dm_4k port of the store buffer.
interface dm_store_buffer_if
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned AW = DmAw
);
  logic             st_valid;
  logic             st_sb;
  logic [AW-1:0]    st_addr;
  logic [DataW-1:0] st_data;
  logic             st_ready;
  logic             ld_valid;
  logic [AW-1:0]    ld_addr;
  logic             ld_stall;
  logic             dm_we;
  logic             dm_sb;
  logic [AW-1:0]    dm_addr;
  logic [DataW-1:0] dm_din;
  logic             empty;

  modport master (
    output st_valid, st_sb, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_stall, dm_we, dm_sb, dm_addr, dm_din, empty
  );

  modport slave (
    input  st_valid, st_sb, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_stall, dm_we, dm_sb, dm_addr, dm_din, empty
  );
endinterface

// File: rtl/dm_store_buffer_sb_fifo.sv
// Circular store FIFO with a parallel word-address compare against the
// current load address.
module dm_store_buffer_sb_fifo
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DmAw
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             push_sb,
  input  logic [AW-1:0]    push_addr,
  input  logic [DataW-1:0] push_data,
  input  logic [AW-1:0]    ld_addr,
  output logic             full,
  output logic             empty,
  output logic             hit,
  output logic             head_sb,
  output logic [AW-1:0]    head_addr,
  output logic [DataW-1:0] head_data
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = entry_w(AW);
  localparam int unsigned SbOff  = sb_off(AW);

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   idx, offs;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= {push_sb, push_addr, push_data};
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_sb   = mem_q[head_q][SbOff];
  assign head_addr = mem_q[head_q][AddrOff +: AW];
  assign head_data = mem_q[head_q][DataOff +: DataW];

  // A slot is live when its distance from head is below count.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx  = PtrW'(i);
      offs = idx - head_q;
      if (({1'b0, offs} < count_q) &&
          (mem_q[idx][AddrOff+2 +: AW-2] == ld_addr[AW-1:2])) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of dm_4k: queues stores, drains one per free
// port cycle, and stalls loads that alias a queued store's word.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DmAw
) (
  input logic               clk,
  input logic               rst,
  dm_store_buffer_if.slave  bus
);
  logic             full, empty, hit, drain, push;
  logic             head_sb;
  logic [AW-1:0]    head_addr;
  logic [DataW-1:0] head_data;

  dm_store_buffer_sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (drain),
    .push_sb   (bus.st_sb),
    .push_addr (bus.st_addr),
    .push_data (bus.st_data),
    .ld_addr   (bus.ld_addr),
    .full      (full),
    .empty     (empty),
    .hit       (hit),
    .head_sb   (head_sb),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  assign push         = bus.st_valid & ~full;
  assign bus.st_ready = ~full;
  assign bus.empty    = empty;
  assign bus.ld_stall = bus.ld_valid & (hit | full);
  // Loads own the port unless they are stalled anyway.
  assign drain        = ~empty & (~bus.ld_valid | bus.ld_stall);

  always_comb begin
    bus.dm_we   = 1'b0;
    bus.dm_sb   = 1'b0;
    bus.dm_addr = bus.ld_addr;
    bus.dm_din  = '0;
    if (drain) begin
      bus.dm_we   = 1'b1;
      bus.dm_sb   = head_sb;
      bus.dm_addr = head_addr;
      bus.dm_din  = head_data;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed vectors, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_dm_store_buffer;
  import dm_store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 12;

  logic clk = 1'b0;
  logic rst;

  dm_store_buffer_if #(.AW(AW)) bus ();

  dm_store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // dm_4k stand-in, and the memory image the model expects.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  always @(posedge clk) begin
    if (bus.dm_we === 1'b1) begin
      if (bus.dm_sb) mem[bus.dm_addr[11:2]][8*bus.dm_addr[1:0] +: 8] <= bus.dm_din[7:0];
      else           mem[bus.dm_addr[11:2]] <= bus.dm_din;
    end
  end

  typedef struct {
    logic        sb;
    logic [11:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   errs   = 0;
  int   checks = 0;
  logic m_full, m_empty, m_hit, m_stall, m_drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic stv, input logic sb, input logic [11:0] sa,
                       input logic [31:0] sd, input logic ldv, input logic [11:0] la);
    rst          = r;
    bus.st_valid = stv;
    bus.st_sb    = sb;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = ldv;
    bus.ld_addr  = la;
  endtask

  function automatic void model_eval();
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    m_hit   = 1'b0;
    foreach (q[k]) if (q[k].addr[11:2] == bus.ld_addr[11:2]) m_hit = 1'b1;
    m_stall = bus.ld_valid && (m_hit || m_full);
    m_drain = !m_empty && (!bus.ld_valid || m_stall);
  endfunction

  function automatic void ref_write(input ent_t e);
    if (e.sb) ref_mem[e.addr[11:2]][8*e.addr[1:0] +: 8] = e.data[7:0];
    else      ref_mem[e.addr[11:2]] = e.data;
  endfunction

  // Check one cycle against the model, then advance the model over the edge.
  task automatic step();
    ent_t e;
    #1;
    model_eval();
    chk("st_ready", bus.st_ready, !m_full);
    chk("empty", bus.empty, m_empty);
    chk("ld_stall", bus.ld_stall, m_stall);
    chk("dm_we", bus.dm_we, m_drain);
    if (m_drain) begin
      chk("drain_addr", bus.dm_addr, q[0].addr);
      chk("drain_sb", bus.dm_sb, q[0].sb);
      chk("drain_din", bus.dm_din, q[0].data);
    end else begin
      chk("ld_addr", bus.dm_addr, bus.ld_addr);
      chk("idle_sb", bus.dm_sb, 1'b0);
      chk("idle_din", bus.dm_din, 32'h0);
    end
    if (bus.ld_valid && !m_stall)
      chk("ld_data", mem[bus.dm_addr[11:2]], ref_mem[bus.ld_addr[11:2]]);
    @(posedge clk);
    if (m_drain) ref_write(q[0]);
    if (rst) q.delete();
    else begin
      if (m_drain) void'(q.pop_front());
      if (bus.st_valid && !m_full) begin
        e.sb = bus.st_sb; e.addr = bus.st_addr; e.data = bus.st_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  typedef struct {
    logic        r, stv, sb;
    logic [11:0] sa;
    logic [31:0] sd;
    logic        ldv;
    logic [11:0] la;
    logic        e_ready, e_stall, e_we;
    logic [11:0] e_addr;
    logic        e_empty, rd_chk;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          i, guard, stalls;
    logic        saw_nr, saw_fs, done, acc;
    logic        r, stv, sb, ldv;
    logic [11:0] sa, la;

    for (int k = 0; k < 1024; k++) begin
      mem[k]     = 32'hA500_0000 | 32'(k);
      ref_mem[k] = 32'hA500_0000 | 32'(k);
    end
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    @(posedge clk);
    #1;

    //         r     stv   sb    sa      sd            ldv   la       rdy   stl   we    addr     emp   rdc   rd
    vecs[0] = '{1'b0, 1'b1, 1'b0, 12'h010, 32'h11223344, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 12'h013, 32'h000000AB, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 12'h010, 1'b1, 1'b1, 1'b1, 12'h013, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 12'h010, 1'b1, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 32'hAB223344};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 12'h104, 32'hCAFEF00D, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 12'h300, 1'b1, 1'b0, 1'b0, 12'h300, 1'b0, 1'b1, 32'hA50000C0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h104, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0};

    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].r, vecs[v].stv, vecs[v].sb, vecs[v].sa, vecs[v].sd, vecs[v].ldv, vecs[v].la);
      #1;
      chk("vec_st_ready", bus.st_ready, vecs[v].e_ready);
      chk("vec_ld_stall", bus.ld_stall, vecs[v].e_stall);
      chk("vec_dm_we", bus.dm_we, vecs[v].e_we);
      chk("vec_dm_addr", bus.dm_addr, vecs[v].e_addr);
      chk("vec_empty", bus.empty, vecs[v].e_empty);
      if (vecs[v].rd_chk) chk("vec_rdata", mem[bus.dm_addr[11:2]], vecs[v].e_rd);
      step();
    end

    // Five stores with a non-hitting load held high: fills, stalls, then drains.
    i = 0; guard = 0; saw_nr = 1'b0; saw_fs = 1'b0;
    while (i < 5 && guard < 50) begin
      drive(1'b0, 1'b1, 1'b0, 12'(12'h100 + 4 * i), 32'h3000_0000 + 32'(i), 1'b1, 12'h200);
      #1;
      acc = bus.st_ready;
      if (!bus.st_ready) begin
        saw_nr = 1'b1;
        if (bus.ld_stall) saw_fs = 1'b1;
      end
      step();
      if (acc) i++;
      guard++;
    end
    chk("t3_all_issued", 32'(i), 32'd5);
    chk("t3_not_ready_seen", saw_nr, 1'b1);
    chk("t3_stall_full_seen", saw_fs, 1'b1);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
      step();
      guard++;
    end
    #1;
    chk("t3_empty", bus.empty, 1'b1);
    for (int k = 0; k < 5; k++) chk("t3_mem", mem[12'h040 + k], 32'h3000_0000 + 32'(k));

    // Two stores to one word, then a load that must wait for both.
    drive(1'b0, 1'b1, 1'b0, 12'h020, 32'h1, 1'b1, 12'h600);
    step();
    drive(1'b0, 1'b1, 1'b0, 12'h020, 32'h2, 1'b1, 12'h600);
    step();
    stalls = 0; done = 1'b0; guard = 0;
    while (!done && guard < 10) begin
      drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h020);
      #1;
      if (!bus.ld_stall) begin
        chk("t5_rdata", mem[bus.dm_addr[11:2]], 32'h2);
        done = 1'b1;
      end else stalls++;
      step();
      guard++;
    end
    chk("t5_done", done, 1'b1);
    chk("t5_stalls", 32'(stalls), 32'd2);

    // Reset with three undrained stores.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 12'(12'h400 + 4 * k), 32'h6000_0000 + 32'(k), 1'b1, 12'h500);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h500);
    step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0);
    #1;
    chk("t6_empty", bus.empty, 1'b1);
    chk("t6_st_ready", bus.st_ready, 1'b1);
    chk("t6_dm_we", bus.dm_we, 1'b0);
    for (int k = 0; k < 3; k++) chk("t6_mem", mem[12'h100 + k], 32'hA500_0100 + 32'(k));
    step();

    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      stv = 1'($urandom_range(0, 1));
      sb  = 1'($urandom_range(0, 1));
      sa  = 12'($urandom_range(0, 63));
      ldv = 1'($urandom_range(0, 1));
      la  = 12'($urandom_range(0, 63));
      drive(r, stv, sb, sa, $urandom, ldv, la);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
